aip_ipcore_slave: RTL and testbench
===================================

// Module: aip_ipcore_slave
// PURPOSE
//  AIP slave interface on the IP-core side of the AIP link. It consumes the
//  dataIn/config/read/write/start strobes driven by the CPU-side AIP bridge and
//  returns dataOut. It owns the input and output buffer memories, the config
//  and status registers, the start/busy/done sequencing and the done interrupt
//  for one attached compute core.
// PARAMETERS
//  IN_DEPTH   16            input buffer depth in words, power of 2
//  OUT_DEPTH  16            output buffer depth in words, power of 2
//  IP_ID      32'h0000_1001 constant returned by the ID register
// PORTS
//  clk           in  1   clock
//  resetn        in  1   asynchronous active-low reset
//  dataInAIP     in  32  write data from the bridge
//  dataOutAIP    out 32  read data to the bridge (registered)
//  configAIP     in  5   register/memory selector
//  readAIP       in  1   read strobe, one cycle
//  writeAIP      in  1   write strobe, one cycle
//  startAIP      in  1   start strobe, one cycle
//  intAIP        out 1   level interrupt = done & int_en
//  core_start    out 1   one-cycle start pulse to the core
//  core_cfg      out 32  CONFIG register contents
//  core_done     in  1   one-cycle completion pulse from the core
//  core_in_addr  in  log2(IN_DEPTH)   core read address, input buffer
//  core_in_data  out 32  input buffer word, 1-cycle read latency
//  core_out_we   in  1   core write enable, output buffer
//  core_out_addr in  log2(OUT_DEPTH)  core write address
//  core_out_data in  32  core write data
// BEHAVIOUR
//  Reset: all registers, pointers, dataOutAIP, intAIP, core_start, busy, done
//   and int_en clear to 0. Buffer contents are not reset.
//  configAIP map, access on writeAIP / readAIP:
//   00 MEM_IN   W: buf_in[wp] <= dataIn, then wp++.  R: returns 0.
//   01 PTR_IN   W: wp <= dataIn[log2(IN_DEPTH)-1:0].  R: {0,wp}.
//   02 MEM_OUT  R: dataOut <= buf_out[rp], then rp++. W: ignored.
//   03 PTR_OUT  W: rp <= dataIn[...].                 R: {0,rp}.
//   04 CONFIG   R/W 32-bit register driving core_cfg.
//   05 STATUS   R: {29'b0,int_en,done,busy}. W: bit0=1 clears done; bit2 -> int_en.
//   1F ID       R: IP_ID.  Any other code: R returns 0, W ignored.
//  Pointers wrap modulo depth: 15 -> 0 with depth 16.
//  Read timing: readAIP in cycle N -> dataOutAIP valid in N+1, held until the
//   next read. Pointer increments apply at the N edge.
//  writeAIP and readAIP in the same cycle: both act. A read of the same location
//   returns the old value.
//  Sequencer states IDLE, RUN, DONE (busy=RUN, done=DONE):
//   IDLE/DONE + startAIP -> core_start=1 for exactly the next cycle, state RUN,
//    done cleared.
//   RUN + core_done -> DONE. startAIP in RUN is ignored, including when it
//    coincides with core_done.
//   core_done outside RUN is ignored.
//  A STATUS done-clear in the same cycle as core_done: the set wins.
//  Core output writes have priority over nothing else. The host cannot write
//   buf_out. A host read of the address the core is writing returns the old value.
//  Reset asserted mid-RUN: state returns to IDLE immediately and core_start is
//   forced to 0. The core must also be reset by the same resetn.
// TESTING
//  1 Reset -> dataOutAIP=0, intAIP=0, STATUS=0, ID read = 32'h0000_1001.
//  2 Write 16 words 0..15 to MEM_IN, then one more word 0xAA -> wp wraps.
//    buf_in[0]=0xAA; core reads addr 1 -> 1 a cycle later.
//  3 Write CONFIG 0x1234, pulse start -> core_start high for one cycle;
//    STATUS=1. Second start while busy -> no core_start.
//  4 STATUS write 4 (int_en), core_done -> STATUS=6, intAIP=1.
//    Write 1 to STATUS -> done=0, intAIP=0.
//  5 Core writes buf_out[3]=0xBEEF. PTR_OUT<=3, read MEM_OUT twice ->
//    0xBEEF, then buf_out[4]; PTR_OUT reads back 5.
//  6 startAIP and core_done in the same cycle while RUN -> DONE, no new
//    core_start. resetn low mid-RUN -> busy=0 immediately.

Source files
------------

// File: rtl/aip_ipcore_slave.sv
// rtl/aip_ipcore_slave.sv - AIP slave on the IP-core side: buffers, config/status, start/done sequencing
//
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   dataInAIP, dataOutAIP            bridge write data in / registered read data out
//   configAIP, readAIP, writeAIP     register/memory selector and one-cycle access strobes
//   startAIP                         one-cycle start strobe from the bridge
//   intAIP                           level interrupt, done & int_en
//   core_start, core_cfg, core_done  start pulse, CONFIG contents, completion pulse
//   core_in_addr, core_in_data       core read port of the input buffer (1-cycle latency)
//   core_out_we/addr/data            core write port of the output buffer
module aip_ipcore_slave #(
    parameter int          IN_DEPTH  = 16,
    parameter int          OUT_DEPTH = 16,
    parameter logic [31:0] IP_ID     = 32'h0000_1001,
    localparam int         IAW       = $clog2(IN_DEPTH),
    localparam int         OAW       = $clog2(OUT_DEPTH)
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic [31:0]    dataInAIP,
    output logic [31:0]    dataOutAIP,
    input  logic [4:0]     configAIP,
    input  logic           readAIP,
    input  logic           writeAIP,
    input  logic           startAIP,
    output logic           intAIP,
    output logic           core_start,
    output logic [31:0]    core_cfg,
    input  logic           core_done,
    input  logic [IAW-1:0] core_in_addr,
    output logic [31:0]    core_in_data,
    input  logic           core_out_we,
    input  logic [OAW-1:0] core_out_addr,
    input  logic [31:0]    core_out_data
);

    localparam logic [4:0] A_MEM_IN  = 5'h00;
    localparam logic [4:0] A_PTR_IN  = 5'h01;
    localparam logic [4:0] A_MEM_OUT = 5'h02;
    localparam logic [4:0] A_PTR_OUT = 5'h03;
    localparam logic [4:0] A_CONFIG  = 5'h04;
    localparam logic [4:0] A_STATUS  = 5'h05;
    localparam logic [4:0] A_ID      = 5'h1F;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } seq_state_t;

    seq_state_t     state_q;
    seq_state_t     state_d;
    logic           start_d;
    logic           busy;
    logic           done;
    logic           int_en;
    logic           status_clr;
    logic [IAW-1:0] wp;
    logic [OAW-1:0] rp;
    logic [31:0]    cfg_q;
    logic [31:0]    rd_data;

    logic [31:0]    buf_in  [IN_DEPTH];
    logic [31:0]    buf_out [OUT_DEPTH];

    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign intAIP     = done & int_en;
    assign core_cfg   = cfg_q;
    assign status_clr = writeAIP && (configAIP == A_STATUS) && dataInAIP[0];

    // Sequencer. A done-clear can only take effect out of DONE, so a
    // core_done arriving in RUN always wins over a simultaneous clear.
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (startAIP) begin
                    state_d = S_RUN;
                    start_d = 1'b1;
                end
            end
            S_RUN: begin
                if (core_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (startAIP) begin
                    state_d = S_RUN;
                    start_d = 1'b1;
                end else if (status_clr) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Host read mux, sampled against the pre-edge state so a same-cycle
    // write or core write is not visible until the following read.
    always_comb begin
        rd_data = '0;
        case (configAIP)
            A_PTR_IN:  rd_data = 32'(wp);
            A_MEM_OUT: rd_data = buf_out[rp];
            A_PTR_OUT: rd_data = 32'(rp);
            A_CONFIG:  rd_data = cfg_q;
            A_STATUS:  rd_data = {29'b0, int_en, done, busy};
            A_ID:      rd_data = IP_ID;
            default:   rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            core_start   <= 1'b0;
            wp           <= '0;
            rp           <= '0;
            cfg_q        <= '0;
            int_en       <= 1'b0;
            dataOutAIP   <= '0;
            core_in_data <= '0;
        end else begin
            state_q      <= state_d;
            core_start   <= start_d;
            core_in_data <= buf_in[core_in_addr];
            if (writeAIP) begin
                case (configAIP)
                    A_MEM_IN:  wp     <= wp + IAW'(1);
                    A_PTR_IN:  wp     <= dataInAIP[IAW-1:0];
                    A_PTR_OUT: rp     <= dataInAIP[OAW-1:0];
                    A_CONFIG:  cfg_q  <= dataInAIP;
                    A_STATUS:  int_en <= dataInAIP[2];
                    default:   ;
                endcase
            end
            if (readAIP) begin
                dataOutAIP <= rd_data;
                if (configAIP == A_MEM_OUT) begin
                    rp <= rp + OAW'(1);
                end
            end
        end
    end

    // Buffer storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (writeAIP && (configAIP == A_MEM_IN)) begin
            buf_in[wp] <= dataInAIP;
        end
        if (core_out_we) begin
            buf_out[core_out_addr] <= core_out_data;
        end
    end

endmodule

// File: tb/tb_aip_ipcore_slave.sv
// tb/tb_aip_ipcore_slave.sv - scoreboard testbench for aip_ipcore_slave
module tb_aip_ipcore_slave;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] dataInAIP;
    logic [31:0] dataOutAIP;
    logic [4:0]  configAIP;
    logic        readAIP;
    logic        writeAIP;
    logic        startAIP;
    logic        intAIP;
    logic        core_start;
    logic [31:0] core_cfg;
    logic        core_done;
    logic [3:0]  core_in_addr;
    logic [31:0] core_in_data;
    logic        core_out_we;
    logic [3:0]  core_out_addr;
    logic [31:0] core_out_data;

    aip_ipcore_slave dut (
        .clk           (clk),
        .resetn        (resetn),
        .dataInAIP     (dataInAIP),
        .dataOutAIP    (dataOutAIP),
        .configAIP     (configAIP),
        .readAIP       (readAIP),
        .writeAIP      (writeAIP),
        .startAIP      (startAIP),
        .intAIP        (intAIP),
        .core_start    (core_start),
        .core_cfg      (core_cfg),
        .core_done     (core_done),
        .core_in_addr  (core_in_addr),
        .core_in_data  (core_in_data),
        .core_out_we   (core_out_we),
        .core_out_addr (core_out_addr),
        .core_out_data (core_out_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model of the slave's architectural state.
    logic [31:0] m_in  [16];
    logic [31:0] m_out [16];
    int          m_wp, m_rp;
    logic [31:0] m_cfg;
    bit          m_busy, m_done, m_inten;

    // Scoreboards: host reads and core input-buffer reads.
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] cexp_q[$];
    bit          core_rd = 1'b0;
    bit          rd_flag = 1'b0;
    bit          crd_flag = 1'b0;

    always @(posedge clk) begin
        rd_flag  <= resetn && readAIP;
        crd_flag <= resetn && core_rd;
    end

    always @(negedge clk) begin
        if (rd_flag) begin
            if (exp_q.size() == 0) chk("host_read_unexpected", dataOutAIP, 32'hxxxx_xxxx);
            else chk(tag_q.pop_front(), dataOutAIP, exp_q.pop_front());
        end
        if (crd_flag) begin
            if (cexp_q.size() == 0) chk("core_read_unexpected", core_in_data, 32'hxxxx_xxxx);
            else chk("core_in_data", core_in_data, cexp_q.pop_front());
        end
    end

    function automatic string cfg_name(input logic [4:0] c);
        case (c)
            5'h00: return "rd_mem_in";
            5'h01: return "rd_ptr_in";
            5'h02: return "rd_mem_out";
            5'h03: return "rd_ptr_out";
            5'h04: return "rd_config";
            5'h05: return "rd_status";
            5'h1F: return "rd_id";
            default: return "rd_unmapped";
        endcase
    endfunction

    // One clock of stimulus. Entered and left at posedge+1.
    task automatic op(input logic [4:0] cfg, input bit wr, input bit rd, input logic [31:0] d,
                      input bit st, input bit cd, input bit cwe, input logic [3:0] cwa,
                      input logic [31:0] cwd, input bit crd, input logic [3:0] cra);
        logic [31:0] e;
        bit          exp_start;
        bit          pre_busy;
        bit          clr;
        configAIP = cfg; writeAIP = wr; readAIP = rd; dataInAIP = d;
        startAIP = st; core_done = cd;
        core_out_we = cwe; core_out_addr = cwa; core_out_data = cwd;
        core_rd = crd; core_in_addr = cra;

        if (rd) begin
            case (cfg)
                5'h01:   e = 32'(m_wp);
                5'h02:   e = m_out[m_rp];
                5'h03:   e = 32'(m_rp);
                5'h04:   e = m_cfg;
                5'h05:   e = {29'b0, m_inten, m_done, m_busy};
                5'h1F:   e = 32'h0000_1001;
                default: e = 32'h0;
            endcase
            exp_q.push_back(e);
            tag_q.push_back(cfg_name(cfg));
            if (cfg == 5'h02) m_rp = (m_rp + 1) % 16;
        end
        if (crd) cexp_q.push_back(m_in[cra]);

        clr = 1'b0;
        if (wr) begin
            case (cfg)
                5'h00: begin m_in[m_wp] = d; m_wp = (m_wp + 1) % 16; end
                5'h01: m_wp = int'(d % 16);
                5'h03: m_rp = int'(d % 16);
                5'h04: m_cfg = d;
                5'h05: begin clr = d[0]; m_inten = d[2]; end
                default: ;
            endcase
        end
        if (cwe) m_out[cwa] = cwd;

        pre_busy  = m_busy;
        exp_start = 1'b0;
        if (st && !pre_busy) begin
            m_busy = 1'b1; m_done = 1'b0; exp_start = 1'b1;
        end else if (cd && pre_busy) begin
            m_busy = 1'b0; m_done = 1'b1;
        end else if (clr) begin
            m_done = 1'b0;
        end

        @(posedge clk); #1;
        writeAIP = 1'b0; readAIP = 1'b0; startAIP = 1'b0; core_done = 1'b0;
        core_out_we = 1'b0; core_rd = 1'b0;
        chk("core_start", {31'b0, core_start}, {31'b0, exp_start});
        chk("intAIP", {31'b0, intAIP}, {31'b0, m_done & m_inten});
        chk("core_cfg", core_cfg, m_cfg);
    endtask

    task automatic host(input logic [4:0] cfg, input bit wr, input bit rd, input logic [31:0] d);
        op(cfg, wr, rd, d, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0);
    endtask

    task automatic seq(input bit st, input bit cd);
        op(5'h00, 1'b0, 1'b0, 32'h0, st, cd, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0);
    endtask

    task automatic core_wr(input logic [3:0] a, input logic [31:0] v);
        op(5'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, a, v, 1'b0, 4'h0);
    endtask

    task automatic core_rd_op(input logic [3:0] a);
        op(5'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, a);
    endtask

    task automatic model_reset();
        m_wp = 0; m_rp = 0; m_cfg = '0;
        m_busy = 1'b0; m_done = 1'b0; m_inten = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        dataInAIP = '0; configAIP = '0; readAIP = 1'b0; writeAIP = 1'b0; startAIP = 1'b0;
        core_done = 1'b0; core_in_addr = '0; core_out_we = 1'b0; core_out_addr = '0;
        core_out_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dataOut", dataOutAIP, 32'h0);
        chk("reset_intAIP", {31'b0, intAIP}, 32'h0);
        chk("reset_core_start", {31'b0, core_start}, 32'h0);
        resetn = 1'b1;

        // Reset state and ID
        host(5'h05, 1'b0, 1'b1, 32'h0);
        host(5'h1F, 1'b0, 1'b1, 32'h0);
        host(5'h01, 1'b0, 1'b1, 32'h0);

        // Input buffer fill with pointer wrap
        for (int i = 0; i < 16; i++) host(5'h00, 1'b1, 1'b0, 32'(i));
        host(5'h00, 1'b1, 1'b0, 32'hAA);
        host(5'h01, 1'b0, 1'b1, 32'h0);
        core_rd_op(4'd1);
        core_rd_op(4'd0);
        core_rd_op(4'd15);
        host(5'h00, 1'b0, 1'b1, 32'h0);

        // CONFIG, start, ignored second start
        host(5'h04, 1'b1, 1'b0, 32'h1234);
        host(5'h04, 1'b0, 1'b1, 32'h0);
        seq(1'b1, 1'b0);
        host(5'h05, 1'b0, 1'b1, 32'h0);
        seq(1'b1, 1'b0);

        // Interrupt enable, completion, done clear
        host(5'h05, 1'b1, 1'b0, 32'h4);
        seq(1'b0, 1'b1);
        host(5'h05, 1'b0, 1'b1, 32'h0);
        host(5'h05, 1'b1, 1'b0, 32'h1);
        host(5'h05, 1'b0, 1'b1, 32'h0);

        // Output buffer: fill, then read with auto-increment
        for (int i = 0; i < 16; i++) core_wr(4'(i), 32'hC000_0000 + 32'(i));
        core_wr(4'd3, 32'hBEEF);
        host(5'h03, 1'b1, 1'b0, 32'h3);
        host(5'h02, 1'b0, 1'b1, 32'h0);
        host(5'h02, 1'b0, 1'b1, 32'h0);
        host(5'h03, 1'b0, 1'b1, 32'h0);
        host(5'h03, 1'b1, 1'b0, 32'hF);
        host(5'h02, 1'b0, 1'b1, 32'h0);
        host(5'h03, 1'b0, 1'b1, 32'h0);
        // Host read of the location the core writes in the same cycle
        op(5'h02, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h1357, 1'b0, 4'h0);
        host(5'h03, 1'b1, 1'b0, 32'h0);
        host(5'h02, 1'b0, 1'b1, 32'h0);

        // Start and core_done together while running; clear racing a set
        host(5'h05, 1'b1, 1'b0, 32'h4);
        seq(1'b1, 1'b0);
        seq(1'b1, 1'b1);
        host(5'h05, 1'b0, 1'b1, 32'h0);
        seq(1'b1, 1'b0);
        op(5'h05, 1'b1, 1'b0, 32'h5, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0);
        host(5'h05, 1'b0, 1'b1, 32'h0);
        seq(1'b0, 1'b1);
        host(5'h05, 1'b0, 1'b1, 32'h0);

        // Reset mid-RUN while core_start is high
        seq(1'b1, 1'b0);
        resetn = 1'b0;
        #1;
        chk("rst_core_start", {31'b0, core_start}, 32'h0);
        chk("rst_intAIP", {31'b0, intAIP}, 32'h0);
        chk("rst_dataOut", dataOutAIP, 32'h0);
        model_reset();
        @(posedge clk); #1;
        resetn = 1'b1;
        host(5'h05, 1'b0, 1'b1, 32'h0);
        host(5'h04, 1'b0, 1'b1, 32'h0);
        core_rd_op(4'd2);

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [4:0] c;
            int r;
            r = $urandom_range(0, 8);
            if (r <= 5)      c = 5'(r);
            else if (r == 6) c = 5'h1F;
            else if (r == 7) c = 5'($urandom_range(6, 30));
            else             c = 5'h02;
            op(c, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom,
               $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 2) == 0, 4'($urandom), $urandom,
               $urandom_range(0, 1) == 1, 4'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("host_queue_drained", 32'(exp_q.size()), 32'h0);
        chk("core_queue_drained", 32'(cexp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
